sq_integral_writer: RTL
=======================

Name: sq_integral_writer

Overview:
- Upstream feeder of the squared-integral-image cache.
- Accepts a raster pixel stream and squares each pixel.
- Keeps a running row sum of squares, reads the previous row's integral value back through the cache write port, and writes II²(y,x) = rowsum²(y,x) + II²(y-1,x) into the cache.
- Cache rows are addressed circularly, so the downstream window reader always sees the last CACHE_ROWS rows.

Parameters:
- PIX_WIDTH, 8: input pixel width.
- WORD_SIZE, 32: integral word width; equals the cache word width.
- IMG_W, 320: pixels per image row.
- IMG_H, 240: rows per frame.
- CACHE_ROWS, 32: rows held in the cache (power of two).
- X_WIDTH, 9: width of the column address (clog2 IMG_W).
- Y_WIDTH, 5: width of the cache row address (clog2 CACHE_ROWS).

Ports:
- clk  in  1  single clock; all logic posedge.
- reset_n  in  1  synchronous active-low reset.
- pix_valid  in  1  pixel available.
- pix_ready  out  1  block accepts a pixel this cycle.
- pix_data  in  PIX_WIDTH  pixel value.
- pix_sof  in  1  qualifies pix_data as first pixel of frame.
- cache_waddrY  out  Y_WIDTH  cache row address.
- cache_waddrX  out  X_WIDTH  cache column address.
- cache_wdata  out  WORD_SIZE  cache write data.
- cache_we  out  1  cache write enable.
- cache_q  in  WORD_SIZE  cache read-back at the presented address.
- row_done  out  1  one-cycle pulse after the last write of a row.
- frame_done  out  1  one-cycle pulse after the last write of a frame.

Behaviour:
- Reset (reset_n=0 at posedge):
  - outputs: pix_ready=0, cache_we=0, cache_waddrY=0, cache_waddrX=0, cache_wdata=0, row_done=0, frame_done=0.
  - internal: x=0, row=0, rowsum=0, state IDLE.
  - Reset mid-operation aborts any pending access; no write is issued after reset.
- FSM states: IDLE, RD, WAIT, CAP, WR.
- IDLE:
  - pix_ready=1, cache_we=0.
  - On pix_valid&&pix_ready: sq = pix_data*pix_data (2*PIX_WIDTH bits, zero-extended); rowsum_n = rowsum + sq, mod 2^WORD_SIZE.
  - If pix_sof=1: x, row and rowsum are cleared before this pixel is processed, so the pixel is treated as (0,0).
  - Next state: row==0 → WR with prev=0; otherwise → RD.
- RD:
  - Drives cache_waddrY = (row-1) mod CACHE_ROWS, cache_waddrX = x, cache_we=0.
  - Address outputs hold through WAIT and CAP.
- WAIT: one idle cycle, covering the cache input register plus the RAM address register.
- CAP:
  - cache_q is valid in this cycle (third cycle counting RD as first) and is captured into prev.
  - Next state: WR.
- WR:
  - Drives cache_we=1 for exactly one cycle, with cache_waddrY = row mod CACHE_ROWS, cache_waddrX = x, cache_wdata = rowsum_n + prev (mod 2^WORD_SIZE).
  - rowsum <= rowsum_n.
  - If x==IMG_W-1:
    - x<=0, rowsum<=0, row<=row+1, and row_done pulses in the next cycle.
    - If row==IMG_H-1: row<=0, and frame_done pulses together with row_done.
  - Otherwise x<=x+1.
  - Next state: IDLE.
- Throughput and latency:
  - Throughput: 1 pixel per 2 cycles on row 0, 1 pixel per 5 cycles on other rows.
  - pix_ready is low outside IDLE.
  - Write latency from acceptance: 1 cycle (row 0) or 4 cycles (others).
- pix_valid may drop at any time. No pixel is consumed unless pix_valid&&pix_ready.
- Cache row wrap: the physical row index wraps at CACHE_ROWS. Logical row 0 of each frame never reads, even if stale data is present.
- pix_sof on a pixel that is not at x=0 (mid-row or mid-frame): the block restarts at (0,0) with no error flag.
- No write is ever issued in RD, WAIT or CAP.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with pix_valid=1 → pix_ready=0, cache_we=0, all outputs 0; first pix_ready=1 in the cycle after release.
- Row 0: pix_sof, then pixels 1,2,3 → writes (Y0,X0)=1, (Y0,X1)=5, (Y0,X2)=14, each cache_we pulse 1 cycle after acceptance; pixel spacing is 2 cycles.
- Row 1:
  - Setup: IMG_W=4, row 0 all 2, row 1 all 3.
  - Row 0 writes are 4, 8, 12, 16.
  - Row 1: RD at Y0 returns those values; writes at Y1 are 13, 26, 39, 52; row_done pulses after the X3 write of each row.
- Wrap and frame:
  - Setup: CACHE_ROWS=4, IMG_H=6.
  - Row 4 writes to Y0 and reads from Y3.
  - frame_done and row_done pulse together after the row 5 / X=IMG_W-1 write.
  - The next sof pixel writes Y0 with no RD.
- Backpressure and gaps: random pix_valid gaps, and pix_data changed while pix_ready=0 → only accepted values are summed; results match the software model over a full 8x8 frame.
- Reset mid-op: assert reset_n=0 in WAIT → no cache_we; after release a pixel 5 with sof → writes 25 at (0,0).

Source files
------------

// File: rtl/sq_integral_writer.sv
// Squared-integral-image writer: squares raster pixels, keeps a running row sum,
// adds the previous row's integral read back from the cache, and writes the result.
module sq_integral_writer #(
  parameter int unsigned PIX_WIDTH  = 8,
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned CACHE_ROWS = 32,
  parameter int unsigned X_WIDTH    = 9,
  parameter int unsigned Y_WIDTH    = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_WIDTH-1:0] pix_data,
  input  logic                 pix_sof,
  output logic [Y_WIDTH-1:0]   cache_waddrY,
  output logic [X_WIDTH-1:0]   cache_waddrX,
  output logic [WORD_SIZE-1:0] cache_wdata,
  output logic                 cache_we,
  input  logic [WORD_SIZE-1:0] cache_q,
  output logic                 row_done,
  output logic                 frame_done
);

  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned SQ_W  = 2 * PIX_WIDTH;
  localparam logic [ROW_W-1:0]   ROW_MASK = ROW_W'(CACHE_ROWS - 1);
  localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(IMG_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, WR} state_t;

  state_t               state;
  logic [X_WIDTH-1:0]   x;
  logic [ROW_W-1:0]     row;
  logic [WORD_SIZE-1:0] rowsum;

  logic                 accept;
  logic [SQ_W-1:0]      sq;
  logic [X_WIDTH-1:0]   x_eff;
  logic [ROW_W-1:0]     row_eff;
  logic [WORD_SIZE-1:0] sum_eff;

  // Start-of-frame restarts position and row sum before the pixel is folded in.
  always_comb begin
    accept  = pix_valid && pix_ready;
    sq      = SQ_W'(pix_data) * SQ_W'(pix_data);
    x_eff   = pix_sof ? '0 : x;
    row_eff = pix_sof ? '0 : row;
    sum_eff = (pix_sof ? '0 : rowsum) + WORD_SIZE'(sq);
  end

  // rowsum already holds rowsum_n from acceptance onward, so WR only advances position.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      x            <= '0;
      row          <= '0;
      rowsum       <= '0;
      pix_ready    <= 1'b0;
      cache_we     <= 1'b0;
      cache_waddrY <= '0;
      cache_waddrX <= '0;
      cache_wdata  <= '0;
      row_done     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      cache_we   <= 1'b0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          pix_ready <= 1'b1;
          if (accept) begin
            pix_ready    <= 1'b0;
            x            <= x_eff;
            row          <= row_eff;
            rowsum       <= sum_eff;
            cache_waddrX <= x_eff;
            if (row_eff == '0) begin
              cache_waddrY <= '0;
              cache_wdata  <= sum_eff;
              cache_we     <= 1'b1;
              state        <= WR;
            end else begin
              cache_waddrY <= Y_WIDTH'((row_eff - ROW_W'(1)) & ROW_MASK);
              state        <= RD;
            end
          end
        end
        RD:   state <= WAIT;
        WAIT: state <= CAP;
        CAP: begin
          cache_waddrY <= Y_WIDTH'(row & ROW_MASK);
          cache_wdata  <= rowsum + cache_q;
          cache_we     <= 1'b1;
          state        <= WR;
        end
        WR: begin
          pix_ready <= 1'b1;
          state     <= IDLE;
          if (x == X_LAST) begin
            x        <= '0;
            rowsum   <= '0;
            row_done <= 1'b1;
            if (row == ROW_LAST) begin
              row        <= '0;
              frame_done <= 1'b1;
            end else begin
              row <= row + ROW_W'(1);
            end
          end else begin
            x <= x + X_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
